// File: rtl/saus_pkg.sv
// saus_pkg: shared types and helpers for the SAUS transform front end.
//   buf_state_t  : occupancy of the two-entry output buffer
//   size_legal() : 1 when 2**size is a usable transform size for `points` lanes
//   lane_mirror(): partner lane of k inside an n-point butterfly
package saus_pkg;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

   function automatic logic size_legal(input int size, input int points);
      return (size >= 1) && (size < 31) && ((1 << size) <= points);
   endfunction

   function automatic int lane_mirror(input int k, input int n);
      return n - 1 - k;
   endfunction

endpackage

// File: rtl/adder.sv
// adder: full-precision signed add, one bit of growth.
//   a, b : signed W-bit operands
//   y    : signed W+1-bit sum
module adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   y
);
   assign y = {a[W-1], a} + {b[W-1], b};
endmodule

// File: rtl/butterfly_skid_buf.sv
// butterfly_skid_buf: two-entry valid/ready buffer (main register + skid).
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : upstream handshake; in_ready is registered and
//                          means "skid register empty"
//   in_data              : DW-bit payload
//   out_valid/out_ready  : downstream handshake
//   out_data             : DW-bit payload, always the main register
module butterfly_skid_buf
   import saus_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   buf_state_t    st, nxt;
   logic [DW-1:0] main_q, skid_q;
   logic          rdy_q;
   logic          acc;
   logic          ld_main, ld_skid, mv_skid;

   assign acc       = in_valid && rdy_q;
   assign in_ready  = rdy_q;
   assign out_valid = (st != BUF_EMPTY);
   assign out_data  = main_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= BUF_EMPTY;
      else        st <= nxt;
   end

   always_comb begin
      nxt     = st;
      ld_main = 1'b0;
      ld_skid = 1'b0;
      mv_skid = 1'b0;
      case (st)
         BUF_EMPTY: begin
            if (acc) begin
               nxt     = BUF_ONE;
               ld_main = 1'b1;
            end
         end
         BUF_ONE: begin
            if (acc && out_ready) begin
               ld_main = 1'b1;              // replace draining entry in place
            end else if (acc) begin
               nxt     = BUF_FULL;
               ld_skid = 1'b1;
            end else if (out_ready) begin
               nxt     = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            // in_ready is low here, so no accept can coincide with the drain
            if (out_ready) begin
               nxt     = BUF_ONE;
               mv_skid = 1'b1;
            end
         end
         default: nxt = BUF_EMPTY;
      endcase
   end

   // Ready is computed from the next state so it never depends on out_ready
   // combinationally; it comes up one edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         if (ld_main)      main_q <= in_data;
         else if (mv_skid) main_q <= skid_q;
         if (ld_skid)      skid_q <= in_data;
         rdy_q <= (nxt != BUF_FULL);
      end
   end

endmodule

// File: rtl/subtractor.sv
// subtractor: full-precision signed subtract, one bit of growth.
//   a, b : signed W-bit operands
//   y    : signed W+1-bit difference a - b
module subtractor #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   y
);
   assign y = {a[W-1], a} - {b[W-1], b};
endmodule

// File: rtl/butterfly_stage.sv
// butterfly_stage: even/odd sum/difference butterfly over up to POINTS lanes,
// transform size chosen per beat, followed by a two-entry skid buffer.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake (in_ready registered)
//   in_data             : POINTS signed WIDTH-bit lanes
//   in_size             : log2(N); illegal values fall back to N = POINTS
//   out_valid/out_ready : output handshake
//   out_data            : POINTS signed WIDTH+1-bit lanes, lanes >= N are 0
//   out_size            : size actually used
//   out_err             : beat carried an illegal in_size
module butterfly_stage
   import saus_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int POINTS = 8,
   parameter int SZW    = $clog2($clog2(POINTS) + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [POINTS*WIDTH-1:0]     in_data,
   input  logic [SZW-1:0]              in_size,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [POINTS*(WIDTH+1)-1:0] out_data,
   output logic [SZW-1:0]              out_size,
   output logic                        out_err
);

   localparam int LP = $clog2(POINTS);
   localparam int DW = POINTS*(WIDTH+1) + SZW + 1;

   logic [POINTS-1:0][WIDTH-1:0]     din;
   logic [LP:1][POINTS-1:0][WIDTH:0] res;   // one full result per legal size
   logic [POINTS-1:0][WIDTH:0]       net;
   logic                             legal;
   logic [SZW-1:0]                   eff_size;
   logic [DW-1:0]                    buf_in, buf_out;

   assign din      = in_data;
   assign legal    = size_legal(int'(in_size), POINTS);
   assign eff_size = legal ? in_size : SZW'(LP);

   // Every size gets its own butterfly; the per-beat size just selects one.
   for (genvar s = 1; s <= LP; s++) begin : g_sz
      localparam int N = 1 << s;
      for (genvar k = 0; k < POINTS; k++) begin : g_ln
         if (k < N/2) begin : g_pair
            localparam int M = lane_mirror(k, N);
            adder      #(.W(WIDTH)) u_add (.a(din[k]), .b(din[M]), .y(res[s][k]));
            subtractor #(.W(WIDTH)) u_sub (.a(din[k]), .b(din[M]), .y(res[s][M]));
         end else if (k >= N) begin : g_zero
            assign res[s][k] = '0;
         end
      end
   end

   always_comb begin
      net = '0;
      for (int s = 1; s <= LP; s++)
         if (int'(eff_size) == s) net = res[s];
   end

   assign buf_in = {net, eff_size, ~legal};

   butterfly_skid_buf #(.DW(DW)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (buf_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   assign {out_data, out_size, out_err} = buf_out;

endmodule

// File: tb/tb_butterfly_stage.sv
module tb_butterfly_stage;

   localparam int W  = 16;
   localparam int P  = 8;
   localparam int OW = W + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [P*W-1:0]   in_data = '0;
   logic [1:0]       in_size = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [P*OW-1:0]  out_data;
   logic [1:0]       out_size;
   logic             out_err;

   int n_chk = 0;
   int n_err = 0;

   butterfly_stage #(.WIDTH(W), .POINTS(P)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_size   (in_size),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_size  (out_size),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int size;
      int din[P];
      int dout[P];
      int osize;
      int oerr;
   } vec_t;

   typedef struct {
      logic [P*OW-1:0] d;
      logic [1:0]      s;
      logic            e;
   } exp_t;

   vec_t tv[6];
   exp_t sb[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_v(input string name, input logic [P*OW-1:0] act, input logic [P*OW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err < 30) $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lane(input int k);
      return int'($signed(out_data[k*OW +: OW]));
   endfunction

   // Independent reference for one beat.
   function automatic exp_t model(input logic [P*W-1:0] d, input logic [1:0] sz);
      exp_t r;
      int   sz_e, n, a, b;
      sz_e = (sz >= 1 && sz <= 3) ? int'(sz) : 3;
      n    = 1 << sz_e;
      r.d  = '0;
      r.s  = 2'(sz_e);
      r.e  = !(sz >= 1 && sz <= 3);
      for (int k = 0; k < n/2; k++) begin
         a = int'($signed(d[k*W +: W]));
         b = int'($signed(d[(n-1-k)*W +: W]));
         r.d[k*OW +: OW]       = OW'(a + b);
         r.d[(n-1-k)*OW +: OW] = OW'(a - b);
      end
      return r;
   endfunction

   function automatic logic [P*W-1:0] pack(input int v[P]);
      logic [P*W-1:0] r;
      for (int k = 0; k < P; k++) r[k*W +: W] = W'(v[k]);
      return r;
   endfunction

   task automatic send_chk(input string name, input logic [P*W-1:0] d, input logic [1:0] sz);
      exp_t e;
      e = model(d, sz);
      chk_i({name, "_valid"}, int'(out_valid), 1);
      chk_v({name, "_data"}, out_data, e.d);
      chk_i({name, "_size"}, int'(out_size), int'(e.s));
   endtask

   logic [P*W-1:0] pa, pb, pc, pd, pe;

   initial begin
      tv[0].size = 2; tv[0].din = '{10, 20, 30, 40, 1, 1, 1, 1};
      tv[0].dout = '{50, 50, -10, -30, 0, 0, 0, 0}; tv[0].osize = 2; tv[0].oerr = 0;
      tv[1].size = 3; tv[1].din = '{32767, -32768, 0, 0, 0, 0, 32767, 32767};
      tv[1].dout = '{65534, -1, 0, 0, 0, 0, -65535, 0}; tv[1].osize = 3; tv[1].oerr = 0;
      tv[2].size = 1; tv[2].din = '{5, -3, 7, 7, 7, 7, 7, 7};
      tv[2].dout = '{2, 8, 0, 0, 0, 0, 0, 0}; tv[2].osize = 1; tv[2].oerr = 0;
      tv[3].size = 0; tv[3].din = '{1, 2, 3, 4, 5, 6, 7, 8};
      tv[3].dout = '{9, 9, 9, 9, -1, -3, -5, -7}; tv[3].osize = 3; tv[3].oerr = 1;
      tv[4].size = 3; tv[4].din = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
      tv[4].dout = '{-1, -65536, -65536, -65536, 0, 0, 0, -65535}; tv[4].osize = 3; tv[4].oerr = 0;
      tv[5].size = 2; tv[5].din = '{100, -100, 7, -7, 9, 9, 9, 9};
      tv[5].dout = '{93, -93, -107, 107, 0, 0, 0, 0}; tv[5].osize = 2; tv[5].oerr = 0;

      // ---- reset state ----
      #12;
      chk_i("rst_out_valid", int'(out_valid), 0);
      chk_i("rst_in_ready", int'(in_ready), 0);
      chk_i("rst_out_data_zero", int'(out_data == '0), 1);
      chk_i("rst_out_size", int'(out_size), 0);
      chk_i("rst_out_err", int'(out_err), 0);
      rst_n = 1'b1;
      tick();
      chk_i("ready_after_rst", int'(in_ready), 1);

      // ---- table vectors, back-to-back, one-cycle latency ----
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_size  = 2'(tv[i].size);
         in_data  = pack(tv[i].din);
         tick();
         chk_i($sformatf("v%0d_valid", i), int'(out_valid), 1);
         for (int k = 0; k < P; k++)
            chk_i($sformatf("v%0d_lane%0d", i, k), lane(k), tv[i].dout[k]);
         chk_i($sformatf("v%0d_size", i), int'(out_size), tv[i].osize);
         chk_i($sformatf("v%0d_err", i), int'(out_err), tv[i].oerr);
      end
      in_valid = 1'b0;
      tick();
      chk_i("idle_out_valid", int'(out_valid), 0);

      // ---- backpressure: A..D with out_ready low for 3 edges ----
      pa = {8{16'h0011}}; pb = {8{16'h8001}}; pc = {8{16'h1234}}; pd = {8{16'hfff0}};
      out_ready = 1'b0;
      in_valid = 1'b1; in_size = 2'd3; in_data = pa;
      tick();                                       // A accepted
      in_data = pb;
      tick();                                       // B accepted -> FULL
      chk_i("bp_ready_low", int'(in_ready), 0);
      send_chk("bp_holdA1", pa, 2'd3);
      in_data = pc;
      tick();                                       // stalled, C not taken
      chk_i("bp_ready_still_low", int'(in_ready), 0);
      send_chk("bp_holdA2", pa, 2'd3);
      out_ready = 1'b1;
      tick();                                       // A drained, B moves up
      chk_i("bp_ready_back", int'(in_ready), 1);
      send_chk("bp_B", pb, 2'd3);
      tick();                                       // C accepted, B drained
      send_chk("bp_C", pc, 2'd3);
      in_data = pd;
      tick();                                       // D accepted, C drained
      send_chk("bp_D", pd, 2'd3);
      in_valid = 1'b0;
      tick();                                       // D drained
      chk_i("bp_empty", int'(out_valid), 0);

      // ---- reset while FULL ----
      out_ready = 1'b0;
      in_valid = 1'b1; in_size = 2'd2; in_data = pa;
      tick();
      in_data = pb;
      tick();
      chk_i("full_before_rst", int'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      chk_i("midrst_out_valid", int'(out_valid), 0);
      chk_i("midrst_in_ready", int'(in_ready), 0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk_i("postrst_ready", int'(in_ready), 1);
      chk_i("postrst_out_valid", int'(out_valid), 0);
      pe = {8{16'h0777}};
      in_valid = 1'b1; in_size = 2'd1; in_data = pe; out_ready = 1'b1;
      tick();
      send_chk("postrst_first", pe, 2'd1);
      in_valid = 1'b0;
      tick();
      chk_i("postrst_drained", int'(out_valid), 0);

      // ---- random valid/ready against the reference model ----
      begin
         exp_t             e;
         logic             stall_prev;
         logic [P*OW+2:0]  prev;
         stall_prev = 1'b0;
         prev = '0;
         for (int i = 0; i < 3000; i++) begin
            if (stall_prev) chk_v("stall_hold", {out_data, out_size, out_err}, prev);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_size   = 2'($urandom_range(0, 3));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) sb.push_back(model(in_data, in_size));
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk_i("rand_unexpected_beat", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk_v("rand_data", out_data, e.d);
                  chk_i("rand_size", int'(out_size), int'(e.s));
                  chk_i("rand_err", int'(out_err), int'(e.e));
               end
            end
            stall_prev = out_valid && !out_ready;
            prev = {out_data, out_size, out_err};
            tick();
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
               if (sb.size() == 0) begin
                  chk_i("drain_unexpected_beat", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk_v("drain_data", out_data, e.d);
               end
            end
            tick();
         end
         chk_i("sb_empty", sb.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
